// File: rtl/int_to_float_multicycle.sv
// int_to_float_multicycle: 32-bit signed integer to IEEE-754 binary32 converter.
// Normalises one bit per cycle, then rounds to nearest even. Strobe/ack
// handshakes on both sides; only one operand is in flight at a time.
module int_to_float_multicycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t      state;
  logic [31:0] a;
  logic [31:0] value;
  logic [7:0]  exp;
  logic        sign;
  logic [22:0] frac;

  logic guard;
  logic round_bit;
  logic sticky;
  logic inc;
  logic carry;

  // Rounding decision from the normalised magnitude (value[31] is the hidden one).
  // The rounded fraction is formed from value[30:8] only: when all those bits are
  // one and we increment, the fraction wraps to zero, which is exactly the
  // 24'h800000 renormalised mantissa, so only the exponent needs the carry.
  always_comb begin
    guard     = value[7];
    round_bit = value[6];
    sticky    = |value[5:0];
    inc       = guard & (round_bit | sticky | value[8]);
    carry     = inc & (&value[30:8]);
  end

  // Conversion FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a            <= '0;
      value        <= '0;
      exp          <= '0;
      sign         <= 1'b0;
      frac         <= '0;
    end else begin
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= CONVERT;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        CONVERT: begin
          if (a == '0) begin
            output_z     <= '0;
            output_z_stb <= 1'b1;
            state        <= PUT_Z;
          end else begin
            sign  <= a[31];
            value <= a[31] ? -a : a;
            exp   <= 8'd31;
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
          if (!value[31]) begin
            value <= value << 1;
            exp   <= exp - 8'd1;
          end else begin
            state <= ROUND;
          end
        end

        ROUND: begin
          frac  <= value[30:8] + {22'd0, inc};
          exp   <= exp + {7'd0, carry};
          state <= PACK;
        end

        PACK: begin
          output_z     <= {sign, exp + 8'd127, frac};
          output_z_stb <= 1'b1;
          state        <= PUT_Z;
        end

        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end

        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_multicycle.sv
// Directed bench for int_to_float_multicycle: values, latency, handshakes, reset.
module tb_int_to_float_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  int_to_float_multicycle dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Offer an operand and return #1 after the input handshake edge.
  task automatic start_op(input logic [31:0] val);
    int n;
    @(negedge clk);
    input_a     = val;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!input_a_ack) begin
      failures++;
      $display("FAIL start_timeout: input_a_ack=%0b required=1", input_a_ack);
      input_a_stb = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
  endtask

  // Count edges from the input handshake until output_z_stb is seen high.
  task automatic wait_stb(output int lat);
    lat = 0;
    while (!output_z_stb && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!output_z_stb) begin
      failures++;
      $display("FAIL stb_timeout: output_z_stb=%0b required=1", output_z_stb);
    end
  endtask

  // Take the result with a single-cycle ack.
  task automatic finish_op();
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL idle_ack: got=%0b required=1", input_a_ack);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: ack=%0b stb=%0b z=%h required 0 0 00000000",
               input_a_ack, output_z_stb, output_z);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (input_a_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_before_edge: got=%0b required=0", input_a_ack);
    end
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL ack_after_release: got=%0b required=1", input_a_ack);
    end
  endtask

  task automatic test_convert();
    logic [31:0] vin [7];
    logic [31:0] vexp [7];
    int          vlat [7];
    int          lat;
    vin[0] = 32'd1;        vexp[0] = 32'h3F800000; vlat[0] = 35;
    vin[1] = 32'hFFFFFFFF; vexp[1] = 32'hBF800000; vlat[1] = 35;
    vin[2] = 32'h80000000; vexp[2] = 32'hCF000000; vlat[2] = 4;
    vin[3] = 32'h00000000; vexp[3] = 32'h00000000; vlat[3] = 1;
    vin[4] = 32'h7FFFFFFF; vexp[4] = 32'h4F000000; vlat[4] = 5;
    vin[5] = 32'h01000001; vexp[5] = 32'h4B800000; vlat[5] = 11;
    vin[6] = 32'h01000003; vexp[6] = 32'h4B800002; vlat[6] = 11;
    for (int i = 0; i < 7; i++) begin
      start_op(vin[i]);
      wait_stb(lat);
      checks++;
      if (output_z !== vexp[i]) begin
        failures++;
        $display("FAIL value[%0d] in=%h: got=%h required=%h", i, vin[i], output_z, vexp[i]);
      end
      checks++;
      if (lat != vlat[i]) begin
        failures++;
        $display("FAIL latency[%0d] in=%h: got=%0d required=%0d", i, vin[i], lat, vlat[i]);
      end
      finish_op();
      checks++;
      if (output_z_stb !== 1'b0) begin
        failures++;
        $display("FAIL stb_clear[%0d]: got=%0b required=0", i, output_z_stb);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(32'd5);
    wait_stb(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (output_z_stb !== 1'b1 || output_z !== 32'h40A00000 || input_a_ack !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: stb=%0b z=%h ack=%0b required 1 40a00000 0",
                 i, output_z_stb, output_z, input_a_ack);
      end
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: stb=%0b ack=%0b required 0 0", output_z_stb, input_a_ack);
    end
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL bp_ack_return: got=%0b required=1", input_a_ack);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    @(negedge clk);
    output_z_ack = 1'b1;
    input_a      = 32'd2;
    input_a_stb  = 1'b1;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    input_a = 32'd3;
    wait_stb(lat);
    checks++;
    if (output_z !== 32'h40000000 || lat != 34) begin
      failures++;
      $display("FAIL b2b_first: z=%h lat=%0d required 40000000 34", output_z, lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
      failures++;
      $display("FAIL b2b_taken: stb=%0b ack=%0b required 0 0", output_z_stb, input_a_ack);
    end
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack: got=%0b required=1", input_a_ack);
    end
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    checks++;
    if (input_a_ack !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: ack=%0b required=0", input_a_ack);
    end
    wait_stb(lat);
    checks++;
    if (output_z !== 32'h40400000 || lat != 34) begin
      failures++;
      $display("FAIL b2b_second: z=%h lat=%0d required 40400000 34", output_z, lat);
    end
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_taken: stb=%0b required=0", output_z_stb);
    end
  endtask

  task automatic test_reset_mid();
    int  lat;
    bit  seen;
    start_op(32'd1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0 || output_z !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: stb=%0b ack=%0b z=%h required 0 0 00000000",
               output_z_stb, input_a_ack, output_z);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    output_z_ack = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (output_z_stb) seen = 1'b1;
    end
    output_z_ack = 1'b0;
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL stale_stb: got=1 required=0");
    end
    start_op(-32'sd7);
    wait_stb(lat);
    checks++;
    if (output_z !== 32'hC0E00000 || lat != 33) begin
      failures++;
      $display("FAIL after_reset: z=%h lat=%0d required c0e00000 33", output_z, lat);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
